dds_ftw_loader: RTL and testbench
=================================

Name: dds_ftw_loader

Overview:
- Upstream stage of the DDS parallel-port programmer.
- Accepts a 48-bit frequency tuning word (FTW) from control logic over a valid/ready handshake.
- Splits the FTW into byte-wide register writes (address + data), MSB first, starting at the FTW1 register address. Each write is handed to the downstream parallel-bus writer, which drives a/d/wrb.
- After the last byte, requests one I/O-update strobe. Bytes whose value is unchanged since the last load are skipped, to minimise bus traffic.

Parameters:
- BASE_ADDR, 6'h04, register address of the most significant FTW byte; subsequent bytes go to BASE_ADDR+1 … BASE_ADDR+NBYTES-1.
- NBYTES, 6, number of bytes in the tuning word; legal range 1..8.
- SKIP_UNCHANGED, 1, 1 = skip bytes equal to the shadow copy; 0 = always write every byte.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  new FTW offered.
- cmd_ready  out  1  loader idle and able to accept an FTW.
- cmd_ftw  in  8*NBYTES  tuning word; bits [8*NBYTES-1 -: 8] are the MSB byte.
- wr_valid  out  1  register write request to the bus writer.
- wr_ready  in  1  bus writer accepts the current write.
- wr_addr  out  6  register address.
- wr_data  out  8  register data.
- upd_req  out  1  request an I/O-update strobe.
- upd_ack  in  1  I/O-update strobe issued.
- cmd_done  out  1  one-cycle pulse when the command is fully processed.
- wr_count  out  4  number of bytes actually written by the last command.

Behaviour:
- Reset (async assert, sync release), all outputs and state cleared:
  - cmd_ready=1, wr_valid=0, wr_addr=0, wr_data=0, upd_req=0, cmd_done=0, wr_count=0.
  - state=IDLE, shadow_valid=0, shadow bytes=0.
- Reset mid-operation aborts immediately. No partial update is requested. Because shadow_valid=0, the next command writes every byte.
- State machine:
  - IDLE: cmd_ready=1. When cmd_valid && cmd_ready, capture cmd_ftw into work register, clear idx and per-command write counter, go to SCAN. cmd_ready drops the following cycle.
  - SCAN, one cycle per byte: the byte needs writing if !SKIP_UNCHANGED, or !shadow_valid, or work byte[idx] != shadow[idx].
    - If it needs writing: load wr_addr=BASE_ADDR+idx, wr_data=work byte[idx]; go to WRITE.
    - Otherwise: if idx==NBYTES-1 go to FINISH, else idx++ and stay in SCAN.
  - WRITE: wr_valid=1. wr_addr and wr_data are held stable until wr_valid && wr_ready. On that handshake edge:
    - shadow[idx] <= data; counter++; wr_valid drops next cycle.
    - If idx==NBYTES-1 go to FINISH, else idx++ and return to SCAN.
  - FINISH, single cycle: set shadow_valid=1 and wr_count=counter. If counter>0 go to UPDATE, else go to DONE.
  - UPDATE: upd_req=1, held until upd_ack is sampled high, then go to DONE. If upd_ack is already high on entry, upd_req is high for exactly one cycle.
  - DONE: cmd_done=1 for one cycle, then IDLE.
- Address arithmetic is 6-bit modulo, wrapping above 6'h3F; no error flag.
- upd_ack is ignored outside UPDATE. wr_ready is ignored while wr_valid=0.
- cmd_valid is ignored while cmd_ready=0 and is not queued; the upstream holds it.
- A new command may be accepted the cycle after cmd_done.
- Minimum latency with NBYTES=6, all bytes written, wr_ready and upd_ack tied high: accept → first wr_valid = 2 cycles; 2 cycles per byte; cmd_done 15 cycles after accept.

Test Plan:
- Reset, then cmd_ftw=48'h0C_CC_CC_CC_CC_CC with wr_ready and upd_ack tied 1 → writes (04,0C),(05,CC),(06,CC),(07,CC),(08,CC),(09,CC) in order; one upd_req; wr_count=6; cmd_done 15 cycles after accept.
- Same FTW resent → zero wr_valid, no upd_req, cmd_done pulses, wr_count=0.
- Then FTW 48'h0C_CC_CC_CC_CC_CD → only write (09,CD); wr_count=1; one upd_req.
- Backpressure: wr_ready low for 5 cycles on the second byte → wr_valid, wr_addr=05 and wr_data stay stable the whole time; no byte is lost or duplicated.
- upd_ack delayed 3 cycles → upd_req high exactly until ack is sampled; cmd_done follows one cycle later; cmd_valid offered during UPDATE is not accepted.
- rst_n pulsed low during the third write → outputs are at reset values asynchronously. Resending the previous FTW then writes all 6 bytes (shadow invalidated).

Source files
------------

// File: rtl/dds_ftw_loader.sv
// Purpose: splits a tuning word into MSB-first byte register writes, skipping unchanged bytes, then requests one I/O update.
// Latency: accept -> first wr_valid 2 cycles, 2 cycles per written byte, 1 per skipped byte; cmd_done ends every command.
// Backpressure: cmd_ready only in IDLE; write held stable until wr_ready; upd_req held until upd_ack.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/ready/ftw   tuning-word command handshake (MSB byte in the top bits)
//   wr_valid/ready        register write handshake to the bus writer, with wr_addr/wr_data
//   upd_req/upd_ack       I/O-update strobe request and acknowledge
//   cmd_done              one-cycle pulse when a command completes
//   wr_count              bytes written by the most recent command
module dds_ftw_loader #(
    parameter logic [5:0] BASE_ADDR      = 6'h04,
    parameter int         NBYTES         = 6,
    parameter bit         SKIP_UNCHANGED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [8*NBYTES-1:0]   cmd_ftw,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [5:0]            wr_addr,
    output logic [7:0]            wr_data,
    output logic                  upd_req,
    input  logic                  upd_ack,
    output logic                  cmd_done,
    output logic [3:0]            wr_count
);

    localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        WRITE,
        FINISH,
        UPDATE,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  work_q   [NBYTES];
    logic [7:0]  work_d   [NBYTES];
    logic [7:0]  shadow_q [NBYTES];
    logic [7:0]  shadow_d [NBYTES];
    logic        shadow_valid_q, shadow_valid_d;
    logic [5:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [3:0]  wr_count_q, wr_count_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        wr_valid_q, wr_valid_d;
    logic        upd_req_q, upd_req_d;
    logic        cmd_done_q, cmd_done_d;
    logic        need_wr;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        work_d         = work_q;
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        wr_count_d     = wr_count_q;

        // A byte is sent unless skipping is enabled and the shadow is known to match it.
        need_wr = !SKIP_UNCHANGED || !shadow_valid_q || (work_q[idx_q] != shadow_q[idx_q]);

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    for (int i = 0; i < NBYTES; i++) begin
                        work_d[i] = cmd_ftw[8*(NBYTES-1-i) +: 8];
                    end
                    idx_d   = 3'd0;
                    cnt_d   = 4'd0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (need_wr) begin
                    // 6-bit address arithmetic wraps silently above 6'h3F.
                    wr_addr_d = BASE_ADDR + {3'b000, idx_q};
                    wr_data_d = work_q[idx_q];
                    state_d   = WRITE;
                end else if (idx_q == LAST_IDX) begin
                    state_d = FINISH;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            WRITE: begin
                if (wr_valid_q && wr_ready) begin
                    shadow_d[idx_q] = wr_data_q;
                    cnt_d           = cnt_q + 4'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = SCAN;
                    end
                end
            end
            FINISH: begin
                shadow_valid_d = 1'b1;
                wr_count_d     = cnt_q;
                state_d        = (cnt_q != 4'd0) ? UPDATE : DONE;
            end
            UPDATE: begin
                if (upd_ack) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake outputs are registered decodes of the next state so they
        // line up exactly with the state they belong to.
        cmd_ready_d = (state_d == IDLE);
        wr_valid_d  = (state_d == WRITE);
        upd_req_d   = (state_d == UPDATE);
        cmd_done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            idx_q          <= 3'd0;
            cnt_q          <= 4'd0;
            shadow_valid_q <= 1'b0;
            wr_addr_q      <= 6'd0;
            wr_data_q      <= 8'd0;
            wr_count_q     <= 4'd0;
            cmd_ready_q    <= 1'b1;
            wr_valid_q     <= 1'b0;
            upd_req_q      <= 1'b0;
            cmd_done_q     <= 1'b0;
            for (int i = 0; i < NBYTES; i++) begin
                work_q[i]   <= 8'd0;
                shadow_q[i] <= 8'd0;
            end
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            shadow_valid_q <= shadow_valid_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            wr_count_q     <= wr_count_d;
            cmd_ready_q    <= cmd_ready_d;
            wr_valid_q     <= wr_valid_d;
            upd_req_q      <= upd_req_d;
            cmd_done_q     <= cmd_done_d;
            for (int i = 0; i < NBYTES; i++) begin
                work_q[i]   <= work_d[i];
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign upd_req   = upd_req_q;
    assign cmd_done  = cmd_done_q;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_dds_ftw_loader.sv
// Purpose: directed table-driven bench for dds_ftw_loader (6-byte FTW at base address 04).
// Latency: commands are timed from the accepting clock edge to the cmd_done pulse.
// Backpressure: wr_ready and upd_ack are throttled per vector to exercise holding behaviour.
module tb_dds_ftw_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [47:0] cmd_ftw;
    logic        wr_valid;
    logic        wr_ready;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        upd_req;
    logic        upd_ack;
    logic        cmd_done;
    logic [3:0]  wr_count;

    always #5 clk = ~clk;

    dds_ftw_loader #(
        .BASE_ADDR      (6'h04),
        .NBYTES         (6),
        .SKIP_UNCHANGED (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ftw   (cmd_ftw),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .upd_req   (upd_req),
        .upd_ack   (upd_ack),
        .cmd_done  (cmd_done),
        .wr_count  (wr_count)
    );

    typedef struct {
        logic [47:0]      ftw;
        int               nwr;
        logic [7:0][13:0] wr;
        int               upd_cyc;
        int               lat;
        int               stall_byte;
        int               stall_len;
        int               ack_delay;
        bit               offer;
    } vec_t;

    vec_t vt [6];

    int errors = 0;
    int checks = 0;

    int          hs_count    = 0;
    int          upd_cycles  = 0;
    int          stall_seen  = 0;
    logic [13:0] got [8];
    logic        prev_stall  = 1'b0;
    logic [13:0] prev_ad     = '0;

    int stall_byte = -1;
    int stall_left = 0;
    int ack_left   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [47:0] ftw, input int nwr, input int upd_cyc,
                                input int lat, input int sb, input int sl, input int ad,
                                input bit offer);
        vec_t v;
        v.ftw        = ftw;
        v.nwr        = nwr;
        v.wr         = '0;
        v.upd_cyc    = upd_cyc;
        v.lat        = lat;
        v.stall_byte = sb;
        v.stall_len  = sl;
        v.ack_delay  = ad;
        v.offer      = offer;
        return v;
    endfunction

    // Downstream responder: throttles wr_ready on one chosen write and upd_ack on entry to UPDATE.
    always @(posedge clk) begin
        #1;
        if (wr_valid && hs_count == stall_byte && stall_left > 0) begin
            wr_ready = 1'b0;
            stall_left--;
        end else begin
            wr_ready = 1'b1;
        end
        if (upd_req && ack_left > 0) begin
            upd_ack = 1'b0;
            ack_left--;
        end else begin
            upd_ack = 1'b1;
        end
    end

    // Monitor: records accepted writes, counts update cycles, and checks a stalled write stays put.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                chk("stall_valid_held", 64'(wr_valid), 64'(1'b1));
                chk("stall_addr_data_held", 64'({wr_addr, wr_data}), 64'(prev_ad));
            end
            if (wr_valid && wr_ready) begin
                if (hs_count < 8) got[hs_count] = {wr_addr, wr_data};
                hs_count++;
            end
            if (upd_req) upd_cycles++;
            prev_stall = wr_valid && !wr_ready;
            prev_ad    = {wr_addr, wr_data};
            if (prev_stall) stall_seen++;
        end
    end

    task automatic clear_monitor();
        hs_count   = 0;
        upd_cycles = 0;
        stall_seen = 0;
        prev_stall = 1'b0;
        for (int i = 0; i < 8; i++) got[i] = '0;
    endtask

    task automatic run_cmd(input int k);
        int n;
        bit done;
        clear_monitor();
        stall_byte = vt[k].stall_byte;
        stall_left = vt[k].stall_len;
        ack_left   = vt[k].ack_delay;
        @(posedge clk);
        #1;
        cmd_ftw   = vt[k].ftw;
        cmd_valid = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d_ready_before_accept", k), 64'(cmd_ready), 64'(1'b1));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        n    = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            if (cmd_done) begin
                done      = 1'b1;
                cmd_valid = 1'b0;
            end else if (vt[k].offer && upd_req) begin
                chk($sformatf("v%0d_no_accept_in_update", k), 64'(cmd_ready), 64'(1'b0));
                cmd_ftw   = 48'hFFFF_FFFF_FFFF;
                cmd_valid = 1'b1;
            end
        end
        chk($sformatf("v%0d_cmd_done_seen", k), 64'(done), 64'(1'b1));
        chk($sformatf("v%0d_latency", k), 64'(n), 64'(vt[k].lat));
        chk($sformatf("v%0d_wr_count", k), 64'(wr_count), 64'(vt[k].nwr));
        chk($sformatf("v%0d_num_writes", k), 64'(hs_count), 64'(vt[k].nwr));
        for (int i = 0; i < vt[k].nwr; i++) begin
            chk($sformatf("v%0d_write%0d", k, i), 64'(got[i]), 64'(vt[k].wr[i]));
        end
        chk($sformatf("v%0d_upd_cycles", k), 64'(upd_cycles), 64'(vt[k].upd_cyc));
        chk($sformatf("v%0d_stall_cycles", k), 64'(stall_seen), 64'(vt[k].stall_len));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1'b1));
        chk({tag, "_wr_valid"},  64'(wr_valid),  64'(1'b0));
        chk({tag, "_wr_addr"},   64'(wr_addr),   64'(6'h00));
        chk({tag, "_wr_data"},   64'(wr_data),   64'(8'h00));
        chk({tag, "_upd_req"},   64'(upd_req),   64'(1'b0));
        chk({tag, "_cmd_done"},  64'(cmd_done),  64'(1'b0));
        chk({tag, "_wr_count"},  64'(wr_count),  64'(4'd0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;

        // Full write of every byte, ready/ack tied high.
        vt[0] = mk(48'h0C_CC_CC_CC_CC_CC, 6, 1, 15, -1, 0, 0, 1'b0);
        vt[0].wr[0] = {6'h04, 8'h0C};
        for (int i = 1; i < 6; i++) vt[0].wr[i] = {6'(4 + i), 8'hCC};
        // Identical word: every byte skipped, no update.
        vt[1] = mk(48'h0C_CC_CC_CC_CC_CC, 0, 0, 8, -1, 0, 0, 1'b0);
        // Only the last byte differs.
        vt[2] = mk(48'h0C_CC_CC_CC_CC_CD, 1, 1, 10, -1, 0, 0, 1'b0);
        vt[2].wr[0] = {6'h09, 8'hCD};
        // Two leading bytes change; second write held off for 5 cycles.
        vt[3] = mk(48'h11_22_CC_CC_CC_CD, 2, 1, 16, 1, 5, 0, 1'b0);
        vt[3].wr[0] = {6'h04, 8'h11};
        vt[3].wr[1] = {6'h05, 8'h22};
        // Update acknowledge delayed 3 cycles while another command is offered.
        vt[4] = mk(48'h11_22_CC_CC_CC_CE, 1, 4, 13, -1, 0, 3, 1'b1);
        vt[4].wr[0] = {6'h09, 8'hCE};
        // After a mid-command reset the shadow is invalid, so every byte goes out.
        vt[5] = mk(48'hA1_A2_A3_A4_A5_A6, 6, 1, 15, -1, 0, 0, 1'b0);
        for (int i = 0; i < 6; i++) vt[5].wr[i] = {6'(4 + i), 8'(8'hA1 + i)};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_ftw   = '0;
        wr_ready  = 1'b1;
        upd_ack   = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("in_reset");
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("after_release");

        for (int k = 0; k < 5; k++) begin
            run_cmd(k);
        end

        // The word offered during UPDATE must not have been latched.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_ready_after_offer", 64'(cmd_ready), 64'(1'b1));
            chk("idle_no_write_after_offer", 64'(wr_valid), 64'(1'b0));
        end

        // Reset asserted while the third byte is on the bus.
        clear_monitor();
        stall_byte = -1;
        @(posedge clk);
        #1;
        cmd_ftw   = 48'hA1_A2_A3_A4_A5_A6;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            if (wr_valid && hs_count == 2) found = 1'b1;
        end
        chk("third_write_reached", 64'(found), 64'(1'b1));
        chk("third_write_addr", 64'(wr_addr), 64'(6'h06));
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        run_cmd(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
